// File: rtl/keypad_pkg.sv
// Shared constants for the 4x3 keypad scanner: matrix geometry, key map
// from scan-register bit (3*row + col) to digit strobe, and FSM states.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // '*' (bit 9) and '#' (bit 11) never count as pressed keys
  localparam logic [NUM_KEYS-1:0] DIGIT_MASK = 12'b0101_1111_1111;

  localparam logic [9:0] KEY_MAP [NUM_KEYS] = '{
    10'b0000000001, 10'b0000000010, 10'b0000000100,
    10'b0000001000, 10'b0000010000, 10'b0000100000,
    10'b0001000000, 10'b0010000000, 10'b0100000000,
    10'b0000000000, 10'b1000000000, 10'b0000000000
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    BLOCKED = 2'd2
  } kp_state_t;

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchroniser; resets to all-ones so idle pulled-up lines
// read as "not pressed" straight out of reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      meta_reg <= '1;
      q_reg    <= '1;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row drive, column debounce, one-hot digit strobe.
// Optional auto-repeat while a single key stays held: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [2:0] cols,
  output logic [3:0] rows,
  output logic [9:0] keypad
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [2:0]          cols_sync;
  logic [1:0]          row_reg;
  logic [DW-1:0]       dwell_reg;
  logic [NUM_KEYS-1:0] scan_reg, scan_next, prev_snap_reg, digits;
  logic [3:0]          stable_reg, stable_next, key_count;
  logic [9:0]          key_oh, strobe_next, keypad_reg;
  logic                sample, scan_done, deb_valid;
  kp_state_t           state_reg, state_next;

  sync2 #(.WIDTH(3)) u_sync (
    .clk    (clk),
    .clearn (clearn),
    .d      (cols),
    .q      (cols_sync)
  );

  assign sample    = (dwell_reg == DW'(SCAN_DIV - 1));
  assign scan_done = sample && (row_reg == 2'd3);
  assign rows      = ~(4'b0001 << row_reg);
  assign keypad    = keypad_reg;

  // scan_next already holds row 3 on the completing cycle, so it is the snapshot
  always_comb begin
    scan_next = scan_reg;
    if (sample)
      scan_next[int'(row_reg) * NUM_COLS +: NUM_COLS] = ~cols_sync;
  end

  always_comb begin
    if (scan_next != prev_snap_reg)
      stable_next = 4'd0;
    else if (stable_reg == 4'd15)
      stable_next = stable_reg;
    else
      stable_next = stable_reg + 4'd1;
  end

  assign deb_valid = scan_done && (stable_next >= 4'(DEBOUNCE_SCANS));
  assign digits    = scan_next & DIGIT_MASK;

  always_comb begin
    key_count = 4'd0;
    key_oh    = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (digits[i]) begin
        key_count = key_count + 4'd1;
        key_oh    = key_oh | KEY_MAP[i];
      end
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      row_reg       <= 2'd0;
      dwell_reg     <= '0;
      scan_reg      <= '0;
      prev_snap_reg <= '0;
      stable_reg    <= 4'd0;
      state_reg     <= IDLE;
      keypad_reg    <= '0;
    end else begin
      if (sample) begin
        dwell_reg <= '0;
        row_reg   <= row_reg + 2'd1;
      end else begin
        dwell_reg <= dwell_reg + DW'(1);
      end
      scan_reg <= scan_next;
      if (scan_done) begin
        prev_snap_reg <= scan_next;
        stable_reg    <= stable_next;
      end
      state_reg  <= state_next;
      keypad_reg <= strobe_next;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);

  logic [RW-1:0]       rep_cnt_reg, rep_cnt_next;
  logic [NUM_KEYS-1:0] held_reg, held_next;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      rep_cnt_reg <= '0;
      held_reg    <= '0;
    end else begin
      rep_cnt_reg <= rep_cnt_next;
      held_reg    <= held_next;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^REPEAT_SCANS;
`endif

  always_comb begin
    state_next  = state_reg;
    strobe_next = '0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_next = rep_cnt_reg;
    held_next    = held_reg;
`endif
    if (deb_valid) begin
      case (state_reg)
        IDLE: begin
          if (key_count == 4'd1) begin
            strobe_next = key_oh;
            state_next  = PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_next = '0;
            held_next    = digits;
`endif
          end else if (key_count >= 4'd2) begin
            state_next = BLOCKED;
          end
        end
        PRESSED: begin
          if (key_count == 4'd0)
            state_next = IDLE;
`ifdef KEYPAD_REPEAT_EN
          // counts only while the very same single key stays debounced
          if (key_count == 4'd1 && digits == held_reg) begin
            if (rep_cnt_reg == RW'(REPEAT_SCANS - 1)) begin
              strobe_next  = key_oh;
              rep_cnt_next = '0;
            end else begin
              rep_cnt_next = rep_cnt_reg + RW'(1);
            end
          end else begin
            rep_cnt_next = '0;
          end
`endif
        end
        BLOCKED: begin
          if (key_count == 4'd0)
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x3 key matrix.
module tb_keypad_scanner;

  localparam int SCAN = 16;

  logic        clk = 1'b0;
  logic        clearn = 1'b0;
  logic [2:0]  cols;
  logic [3:0]  rows;
  logic [9:0]  keypad;
  logic [11:0] held = '0;

  int checks = 0, passes = 0, fails = 0;
  int cycle = 0, strobe_cnt = 0, wide_cnt = 0, bad_val = 0;
  int first_cyc = -1, last_cyc = -1, last_gap = 0, press_cyc = 0;
  logic [9:0] exp_val = '0;
  logic [9:0] prev_kp = '0;

  always #5 clk = ~clk;

  always_comb begin
    cols = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (held[r*3+c] && !rows[r]) cols[c] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
`ifdef KEYPAD_REPEAT_EN
    .REPEAT_SCANS   (8)
`else
    .REPEAT_SCANS   (32)
`endif
  ) dut (
    .clk    (clk),
    .clearn (clearn),
    .cols   (cols),
    .rows   (rows),
    .keypad (keypad)
  );

  always @(negedge clk) begin
    cycle++;
    if (keypad != '0) begin
      strobe_cnt++;
      if (keypad !== exp_val) bad_val++;
      if (prev_kp != '0) wide_cnt++;
      if (first_cyc < 0) first_cyc = cycle;
      else last_gap = cycle - last_cyc;
      last_cyc = cycle;
      $display("strobe cycle=%0d keypad=%b expected=%b", cycle, keypad, exp_val);
    end
    prev_kp = keypad;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon(input logic [9:0] e);
    exp_val    = e;
    strobe_cnt = 0;
    wide_cnt   = 0;
    bad_val    = 0;
    first_cyc  = -1;
    last_cyc   = -1;
    press_cyc  = cycle;
  endtask

  // one strobe per press, or at least one when auto-repeat is built in
  task automatic check_once(input string tag);
`ifdef KEYPAD_REPEAT_EN
    check(tag, 32'(strobe_cnt >= 1), 32'd1);
`else
    check(tag, 32'(strobe_cnt), 32'd1);
`endif
    check({tag, "_val"}, 32'(bad_val), 32'd0);
    check({tag, "_width"}, 32'(wide_cnt), 32'd0);
  endtask

  initial begin
    // reset state
    wait_cycles(3);
    check("reset_rows", 32'(rows), 32'hE);
    check("reset_keypad", 32'(keypad), 32'd0);
    clearn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic [3:0] er;
      er = ~(4'b0001 << (((k + 1) / 4) % 4));
      wait_cycles(1);
      check($sformatf("row_seq%0d", k), 32'(rows), 32'(er));
    end
    wait_cycles(10 * SCAN);
    check("idle_no_strobe", 32'(strobe_cnt), 32'd0);

    // hold key 5
    clear_mon(10'b0000010000);
    held = 12'b0000_0001_0000;
    wait_cycles(40 * SCAN);
    check_once("key5");
    check("key5_latency", 32'(first_cyc >= 0 && (first_cyc - press_cyc) <= 5 * SCAN), 32'd1);
    held = '0;
    wait_cycles(10 * SCAN);

    // bounce key 1, then hold
    clear_mon(10'b0000000001);
    for (int t = 0; t < 12; t++) begin
      held[0] = ~held[0];
      wait_cycles(10);
    end
    check("bounce_quiet", 32'(strobe_cnt), 32'd0);
    held = 12'b0000_0000_0001;
    wait_cycles(20 * SCAN);
    check_once("key1");
    held = '0;
    wait_cycles(10 * SCAN);

    // chord 1+4 blocked, then 0
    clear_mon(10'b0000000000);
    held = 12'b0000_0000_1001;
    wait_cycles(20 * SCAN);
    check("chord_blocked", 32'(strobe_cnt), 32'd0);
    held = '0;
    wait_cycles(10 * SCAN);
    clear_mon(10'b1000000000);
    held = 12'b0100_0000_0000;
    wait_cycles(20 * SCAN);
    check_once("key0");
    held = '0;
    wait_cycles(10 * SCAN);

    // '*' and '#' ignored
    clear_mon(10'b0000000000);
    held = 12'b0010_0000_0000;
    wait_cycles(20 * SCAN);
    check("star_ignored", 32'(strobe_cnt), 32'd0);
    held = 12'b1000_0000_0000;
    wait_cycles(20 * SCAN);
    check("hash_ignored", 32'(strobe_cnt), 32'd0);
    held = '0;
    wait_cycles(10 * SCAN);

    // second key while 5 is held gives nothing for 2
    clear_mon(10'b0000010000);
    held = 12'b0000_0001_0000;
    wait_cycles(20 * SCAN);
    held = 12'b0000_0001_0010;
    wait_cycles(20 * SCAN);
    check_once("key5_then_2");
    held = '0;
    wait_cycles(10 * SCAN);

    // reset mid-hold of 7
    clear_mon(10'b0001000000);
    held = 12'b0000_0100_0000;
    wait_cycles(20 * SCAN);
    check_once("key7_before_rst");
    clearn = 1'b0;
    wait_cycles(5);
    check("rst_keypad", 32'(keypad), 32'd0);
    check("rst_rows", 32'(rows), 32'hE);
    clear_mon(10'b0001000000);
    clearn = 1'b1;
    wait_cycles(20 * SCAN);
    check_once("key7_after_rst");
    held = '0;
    wait_cycles(10 * SCAN);

`ifdef KEYPAD_REPEAT_EN
    clear_mon(10'b0100000000);
    held = 12'b0001_0000_0000;
    wait_cycles(30 * SCAN);
    check("rep_count", 32'(strobe_cnt >= 3), 32'd1);
    check("rep_gap", 32'(last_gap), 32'd128);
    check("rep_val", 32'(bad_val), 32'd0);
    held = '0;
    wait_cycles(10 * SCAN);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
